// File: rtl/mux31_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux31_rr_arbiter
//
// Round-robin arbiter that sequences the select lines of a shared 3:1 mux.
// Three requesters compete for the datapath. The winner receives a registered
// one-hot grant and drives the matching mux select code. The selected data word
// is registered into y together with a valid flag. A requester keeps the grant
// for at most MAX_HOLD consecutive cycles while another requester is waiting.
//
// Handshake: req[i] is a level request from source i. While grant[i] is high,
// source i owns the mux. If it drops req[i], the grant is released at the next
// edge. y/y_valid show the word that the mux selected during the previous cycle.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   req      in   [2:0] request per source (req[i] pairs with di)
//   d0/d1/d2 in   [WIDTH-1:0] source data
//   grant    out  [2:0] one-hot registered grant, 000 when idle
//   s0/s1    out  mux select bits (00 -> d0, 01 -> d1, 10 -> d2)
//   y        out  [WIDTH-1:0] registered mux output
//   y_valid  out  y holds data from a granted source
//   busy     out  FSM state indicator, high while in GRANT
// -----------------------------------------------------------------------------
module mux31_rr_arbiter #(
    parameter int WIDTH    = 1,
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       req,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    output logic [2:0]       grant,
    output logic             s0,
    output logic             s1,
    output logic [WIDTH-1:0] y,
    output logic             y_valid,
    output logic             busy
);

    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_ONE = HW'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       grant_q, grant_d;
    logic [1:0]       sel_q, sel_d;     // {s1, s0}
    logic [1:0]       last_q, last_d;   // index of the most recent owner
    logic [HW-1:0]    hold_q, hold_d;
    logic [2:0]       others;
    logic [1:0]       winner;
    logic [WIDTH-1:0] mux_out;

    // Pick the first asserted request, searching last+1, last+2, last (mod 3).
    function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
        logic [1:0] w;
        w = 2'd0;
        case (last)
            2'd0:    w = r[1] ? 2'd1 : (r[2] ? 2'd2 : 2'd0);
            2'd1:    w = r[2] ? 2'd2 : (r[0] ? 2'd0 : 2'd1);
            default: w = r[0] ? 2'd0 : (r[1] ? 2'd1 : 2'd2);
        endcase
        return w;
    endfunction

    function automatic logic [2:0] to_onehot(input logic [1:0] idx);
        logic [2:0] oh;
        oh = 3'b000;
        case (idx)
            2'd0:    oh = 3'b001;
            2'd1:    oh = 3'b010;
            default: oh = 3'b100;
        endcase
        return oh;
    endfunction

    // In GRANT, last_q always names the current owner, so searching from
    // last_q+1 is both the normal rotation and the "start at g+1" preemption.
    assign others = req & ~grant_q;
    assign winner = rr_pick(req, last_q);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        last_d  = last_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    grant_d = to_onehot(winner);
                    sel_d   = winner;
                    last_d  = winner;
                    hold_d  = HOLD_ONE;
                    state_d = GRANT;
                end else begin
                    grant_d = 3'b000;
                end
            end
            GRANT: begin
                if (!(|(req & grant_q))) begin
                    // Owner released: hand over directly, no idle bubble.
                    if (|others) begin
                        grant_d = to_onehot(winner);
                        sel_d   = winner;
                        last_d  = winner;
                        hold_d  = HOLD_ONE;
                    end else begin
                        grant_d = 3'b000;
                        state_d = IDLE;
                    end
                end else if (!(|others)) begin
                    // Sole requester: keep grant, counter saturates.
                    if (hold_q != HOLD_MAX) begin
                        hold_d = hold_q + HOLD_ONE;
                    end
                end else if (hold_q == HOLD_MAX) begin
                    grant_d = to_onehot(winner);
                    sel_d   = winner;
                    last_d  = winner;
                    hold_d  = HOLD_ONE;
                end else begin
                    hold_d = hold_q + HOLD_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 3'b000;
            end
        endcase
    end

    always_comb begin
        mux_out = d2;
        case (sel_q)
            2'b00:   mux_out = d0;
            2'b01:   mux_out = d1;
            default: mux_out = d2;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= 3'b000;
            sel_q   <= 2'b00;
            last_q  <= 2'd2;
            hold_q  <= '0;
            y       <= '0;
            y_valid <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
            // Capture the word selected during the cycle that just ended.
            if (grant_q != 3'b000) begin
                y       <= mux_out;
                y_valid <= 1'b1;
            end else begin
                y_valid <= 1'b0;
            end
        end
    end

    assign grant = grant_q;
    assign s0    = sel_q[0];
    assign s1    = sel_q[1];
    assign busy  = (state_q == GRANT);

endmodule
